// File: rtl/tdm_demux.sv
`default_nettype none
// ============================================================================
// Module   : tdm_demux
// Brief    : Serial TDM frame demultiplexer into CHANNELS registered words.
//            Optional trailing even-parity bit when TDM_DEMUX_PARITY_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
module tdm_demux #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        din,
  input  logic                        din_valid,
  input  logic                        frame_sync,
  output logic [CHANNELS*WIDTH-1:0]   ch_data,
  output logic                        frame_valid,
  output logic                        frame_err,
  output logic                        busy
);

  localparam int c_N     = CHANNELS * WIDTH;
  localparam int c_CNT_W = $clog2(c_N + 1);
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_N - 1);
  localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);
`ifdef TDM_DEMUX_PARITY_EN
  localparam int c_SH_W = c_N;
`else
  // The last data bit goes straight from din into ch_data, so one bit less.
  localparam int c_SH_W = c_N - 1;
`endif

  localparam logic [1:0] c_HUNT   = 2'd0;
  localparam logic [1:0] c_RECV   = 2'd1;
`ifdef TDM_DEMUX_PARITY_EN
  localparam logic [1:0] c_PARITY = 2'd2;
`endif

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_SH_W-1:0]  r_shift;
  logic [c_SH_W-1:0]  w_shift_nxt;
  logic [c_N-1:0]     w_frame;
  logic [c_N-1:0]     w_ch_word;
  logic               w_start;
  logic               w_shift;
  logic               w_load;
  logic               w_abort;
`ifdef TDM_DEMUX_PARITY_EN
  logic               r_par;
  logic               w_par_bad;
`endif

  // w_frame holds channel 0 in its top slot (first bit received is the MSB).
`ifdef TDM_DEMUX_PARITY_EN
  assign w_frame     = r_shift;
  assign w_shift_nxt = {r_shift[c_N-2:0], din};
  assign w_par_bad   = r_par ^ din;
`else
  assign w_frame     = {r_shift, din};
  assign w_shift_nxt = w_frame[c_N-2:0];
`endif

  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    assign w_ch_word[k*WIDTH +: WIDTH] = w_frame[(CHANNELS-1-k)*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= c_HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (din_valid) begin
      case (r_state)
        c_HUNT: begin
          if (frame_sync) w_state_nxt = c_RECV;
        end
        c_RECV: begin
          if (!frame_sync && (r_cnt == c_LAST)) begin
`ifdef TDM_DEMUX_PARITY_EN
            w_state_nxt = c_PARITY;
`else
            w_state_nxt = c_HUNT;
`endif
          end
        end
`ifdef TDM_DEMUX_PARITY_EN
        c_PARITY: begin
          w_state_nxt = frame_sync ? c_RECV : c_HUNT;
        end
`endif
        default: w_state_nxt = c_HUNT;
      endcase
    end
  end

  // A sync bit inside a frame always wins: it aborts and restarts as bit 0.
  always_comb begin
    w_start = 1'b0;
    w_shift = 1'b0;
    w_load  = 1'b0;
    w_abort = 1'b0;
    busy    = (r_state != c_HUNT);
    if (din_valid) begin
      case (r_state)
        c_HUNT: begin
          w_start = frame_sync;
        end
        c_RECV: begin
          w_start = frame_sync;
          w_abort = frame_sync;
          w_shift = !frame_sync;
`ifndef TDM_DEMUX_PARITY_EN
          w_load  = !frame_sync && (r_cnt == c_LAST);
`endif
        end
`ifdef TDM_DEMUX_PARITY_EN
        c_PARITY: begin
          w_start = frame_sync;
          w_abort = frame_sync || w_par_bad;
          w_load  = !frame_sync && !w_par_bad;
        end
`endif
        default: begin
          w_start = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_shift     <= '0;
      ch_data     <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      r_par       <= 1'b0;
`endif
    end else begin
      frame_valid <= w_load;
      frame_err   <= w_abort;
      if (w_load) ch_data <= w_ch_word;

      if (w_start) begin
        r_cnt   <= c_ONE;
        r_shift <= c_SH_W'(din);
`ifdef TDM_DEMUX_PARITY_EN
        r_par   <= din;
`endif
      end else if (w_state_nxt == c_HUNT) begin
        r_cnt <= '0;
      end else if (w_shift) begin
        r_cnt   <= r_cnt + c_ONE;
        r_shift <= w_shift_nxt;
`ifdef TDM_DEMUX_PARITY_EN
        r_par   <= r_par ^ din;
`endif
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/tdm_demux.md
TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 Parameter CHANNELS, default 4: number of output channels; legal range 2..16.
REQ-002 Parameter WIDTH, default 8: bits per channel slot; legal range 1..32.
REQ-003 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 din  input  1  serial TDM data bit.
REQ-006 din_valid  input  1  din is qualified this cycle; the block SHALL ignore din and frame_sync when it is low.
REQ-007 frame_sync  input  1  marks the first bit of a frame; only meaningful with din_valid.
REQ-008 ch_data  output  CHANNELS*WIDTH  registered channel words; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-009 frame_valid  output  1  one-cycle pulse: ch_data updated with a complete good frame.
REQ-010 frame_err  output  1  one-cycle pulse: frame aborted or rejected.
REQ-011 busy  output  1  high while in any state other than HUNT.

Function
REQ-012 Frame format: channel 0 slot first, channel CHANNELS-1 last, MSB first within each slot; data length N = CHANNELS*WIDTH bits.
REQ-013 States: HUNT, RECV, plus PARITY when the configuration feature is compiled in.
REQ-014 HUNT: an accepted bit with frame_sync=1 SHALL be stored as frame bit 0 and SHALL move the block to RECV with bit count 1; an accepted bit with frame_sync=0 SHALL be discarded.
REQ-015 RECV: each accepted bit SHALL be shifted in and SHALL increment the bit count; the state and count SHALL be held when din_valid=0.
REQ-016 On acceptance of bit N-1 without parity: ch_data SHALL load the assembled frame on that clock edge, frame_valid SHALL be high in the following cycle, and the state SHALL return to HUNT.
REQ-017 Latency: from the clock edge that accepts the last frame bit to frame_valid high SHALL be exactly 1 cycle.
REQ-018 Back-to-back frames: a frame_sync bit in the cycle immediately after the last bit SHALL be accepted as bit 0 of the next frame, with no gap cycle.
REQ-019 Early sync: frame_sync=1 on an accepted bit in RECV at count>0 SHALL pulse frame_err, discard the partial frame, and restart with that bit as bit 0, staying in RECV with count 1.
REQ-020 ch_data SHALL change only on good-frame completion; aborted or rejected frames SHALL leave it unchanged.
REQ-021 frame_valid and frame_err SHALL never be high in the same cycle.
REQ-022 The bit counter SHALL be sized ceil(log2(N+1)) and SHALL never wrap within a frame.

Reset
REQ-023 rst_n=0 at a clock edge SHALL force: state HUNT, bit count 0, shift register 0, ch_data 0, frame_valid 0, frame_err 0, busy 0.
REQ-024 Reset mid-frame SHALL discard the partial frame with no frame_err pulse; the first accepted frame_sync bit after release SHALL start a new frame.

Configuration
REQ-025 Macro TDM_DEMUX_PARITY_EN defined: one even-parity bit SHALL follow bit N-1 and is handled in the PARITY state. Total parity over data plus parity bit even: ch_data is loaded and frame_valid pulses. Odd: frame_err pulses and ch_data is kept. Latency is 1 cycle after the parity bit. frame_sync on the parity bit SHALL be treated as an early sync (REQ-019).
REQ-026 Macro TDM_DEMUX_PARITY_EN not defined: there is no PARITY state or parity logic, and the frame is exactly N bits.

Verification (CHANNELS=4, WIDTH=8, macro undefined unless stated)
REQ-027 Send frame 0xA5,0x3C,0xFF,0x01 with sync on bit 0, valid continuous -> 1 cycle after bit 31, frame_valid=1 and ch_data=0x01FF3CA5.
REQ-028 Same frame with din_valid low on every other cycle -> identical ch_data; frame_valid comes 1 cycle after the last accepted bit.
REQ-029 Two back-to-back frames 0x11223344 then 0x55667788 (per-channel bytes) -> two frame_valid pulses 32 cycles apart, with ch_data updated each time.
REQ-030 frame_sync reasserted at bit 12, followed by a full good frame -> frame_err pulse at that point, then one frame_valid carrying only the new frame's data.
REQ-031 rst_n low for 1 cycle at bit 20, then a full frame -> no frame_err, ch_data reads 0 until the new frame's frame_valid.
REQ-032 With TDM_DEMUX_PARITY_EN defined: a good parity bit -> frame_valid; a flipped parity bit -> frame_err with ch_data unchanged.
